vj_detection_fifo: RTL and testbench

Buffers face detections emitted by the Viola-Jones cascade pipeline (`vj_pipeline`) until a host-side reader drains them. Each cycle that the pipeline reports a passing window, the block captures the window's top-left coordinate, pyramid level and total stage score. It presents them in order on a valid/ready output port. The block sits directly downstream of the cascade pipeline and upstream of the result readout (UART/host interface). It also tracks overflow and per-frame detection statistics.

---
 rtl/vj_detection_fifo.sv | 79 +++++++
 tb/tb_vj_detection_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vj_detection_fifo.sv
// Detection FIFO between the Viola-Jones cascade and the host readout: buffers passing
// windows in order, first-word fall-through, with sticky overflow and saturating per-frame stats.
module vj_detection_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       frame_clear,
  input  logic                       in_window_valid,
  input  logic                       in_top_left_ready,
  input  logic [1:0][31:0]           in_top_left,
  input  logic [3:0]                 in_pyramid_number,
  input  logic [31:0]                in_accum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0][31:0]           out_top_left,
  output logic [3:0]                 out_pyramid_number,
  output logic [31:0]                out_accum,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count,
  output logic [CNT_W-1:0]           detect_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [99:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          det;
  logic          pop;
  logic          push;
  logic          drop;
  logic          full;

  assign det  = in_window_valid & in_top_left_ready;
  assign pop  = out_valid & out_ready;
  assign full = (count == CW'(DEPTH));
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push = det & (~full | pop);
  assign drop = det & ~push;

  assign out_valid = (count != '0);
  assign {out_pyramid_number, out_top_left[1], out_top_left[0], out_accum} = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      detect_count <= '0;
    end else if (frame_clear) begin
      // Array contents are left alone; the zeroed count makes them invisible.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      detect_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_pyramid_number, in_top_left[1], in_top_left[0], in_accum};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) overflow <= 1'b1;
      if (drop && drop_count != {CNT_W{1'b1}})  drop_count   <= drop_count + CNT_W'(1);
      if (det && detect_count != {CNT_W{1'b1}}) detect_count <= detect_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vj_detection_fifo.sv
// Directed bench for vj_detection_fifo: a queue-based model checked every cycle on two
// instances (16-bit and 4-bit statistics), plus literal expectations for the test plan.
module tb_vj_detection_fifo;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             frame_clear = 1'b0;
  logic             in_window_valid = 1'b0;
  logic             in_top_left_ready = 1'b0;
  logic [1:0][31:0] in_top_left = '0;
  logic [3:0]       in_pyramid_number = '0;
  logic [31:0]      in_accum = '0;
  logic             out_ready = 1'b0;

  logic             out_valid, out_valid4;
  logic [1:0][31:0] out_top_left, out_top_left4;
  logic [3:0]       out_pyramid_number, out_pyramid_number4;
  logic [31:0]      out_accum, out_accum4;
  logic [4:0]       count, count4;
  logic             overflow, overflow4;
  logic [15:0]      drop_count, detect_count;
  logic [3:0]       drop_count4, detect_count4;

  int passed = 0;
  int total  = 0;

  vj_detection_fifo #(.DEPTH(16), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .frame_clear(frame_clear),
    .in_window_valid(in_window_valid), .in_top_left_ready(in_top_left_ready),
    .in_top_left(in_top_left), .in_pyramid_number(in_pyramid_number), .in_accum(in_accum),
    .out_valid(out_valid), .out_ready(out_ready), .out_top_left(out_top_left),
    .out_pyramid_number(out_pyramid_number), .out_accum(out_accum), .count(count),
    .overflow(overflow), .drop_count(drop_count), .detect_count(detect_count)
  );

  vj_detection_fifo #(.DEPTH(16), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .frame_clear(frame_clear),
    .in_window_valid(in_window_valid), .in_top_left_ready(in_top_left_ready),
    .in_top_left(in_top_left), .in_pyramid_number(in_pyramid_number), .in_accum(in_accum),
    .out_valid(out_valid4), .out_ready(out_ready), .out_top_left(out_top_left4),
    .out_pyramid_number(out_pyramid_number4), .out_accum(out_accum4), .count(count4),
    .overflow(overflow4), .drop_count(drop_count4), .detect_count(detect_count4)
  );

  always #5 clock = ~clock;

  // Model: ordered queue of {pyr, y, x, accum} plus plain integer statistics.
  logic [99:0] mq[$];
  bit          m_ovf;
  int          m_drop, m_det;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ovf  = 0;
    m_drop = 0;
    m_det  = 0;
  endtask

  always @(posedge clock) begin
    if (reset || frame_clear) begin
      model_clear();
    end else begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (in_window_valid && in_top_left_ready) begin
        m_det++;
        if (mq.size() < 16)
          mq.push_back({in_pyramid_number, in_top_left[1], in_top_left[0], in_accum});
        else begin
          m_ovf = 1;
          m_drop++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clock) begin
    chk("model count",      128'(count),         128'(mq.size()));
    chk("model count4",     128'(count4),        128'(mq.size()));
    chk("model out_valid",  128'(out_valid),     128'(mq.size() != 0));
    chk("model overflow",   128'(overflow),      128'(m_ovf));
    chk("model overflow4",  128'(overflow4),     128'(m_ovf));
    chk("model drop",       128'(drop_count),    128'(sat(m_drop, 16)));
    chk("model detect",     128'(detect_count),  128'(sat(m_det, 16)));
    chk("model drop4",      128'(drop_count4),   128'(sat(m_drop, 4)));
    chk("model detect4",    128'(detect_count4), 128'(sat(m_det, 4)));
    if (mq.size() != 0) begin
      chk("model head",  128'({out_pyramid_number, out_top_left[1], out_top_left[0], out_accum}),
          128'(mq[0]));
      chk("model head4", 128'({out_pyramid_number4, out_top_left4[1], out_top_left4[0], out_accum4}),
          128'(mq[0]));
    end
  end

  // One clock: drive inputs, wait for the edge, return 1 time unit after it.
  task automatic cyc(input logic wv, input logic tlr, input logic [31:0] x, input logic [31:0] y,
                     input logic [3:0] pyr, input logic [31:0] acc, input logic rdy, input logic fc);
    in_window_valid   = wv;
    in_top_left_ready = tlr;
    in_top_left[0]    = x;
    in_top_left[1]    = y;
    in_pyramid_number = pyr;
    in_accum          = acc;
    out_ready         = rdy;
    frame_clear       = fc;
    @(posedge clock);
    #1;
  endtask

  task automatic det_cyc(input int x, input logic rdy);
    logic [31:0] xv;
    xv = 32'(x);
    cyc(1'b1, 1'b1, xv, xv + 32'd1000, xv[3:0], ~xv, rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy, input logic fc);
    cyc(1'b0, 1'b0, '0, '0, '0, '0, rdy, fc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, " count"},     128'(count), 128'(0));
    chk({tag, " data"},      128'({out_pyramid_number, out_top_left, out_accum}), 128'(0));
    chk({tag, " overflow"},  128'(overflow), 128'(0));
    chk({tag, " drop"},      128'(drop_count), 128'(0));
    chk({tag, " detect"},    128'(detect_count), 128'(0));
    chk({tag, " count4"},    128'(count4), 128'(0));
    chk({tag, " data4"},     128'({out_pyramid_number4, out_top_left4, out_accum4}), 128'(0));
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    idle(1'b0, 1'b0);

    // Single detection
    cyc(1'b1, 1'b1, 32'd5, 32'd7, 4'd3, 32'hFFFFFF80, 1'b0, 1'b0);
    chk("single valid", 128'(out_valid), 128'(1));
    chk("single x",     128'(out_top_left[0]), 128'(5));
    chk("single y",     128'(out_top_left[1]), 128'(7));
    chk("single pyr",   128'(out_pyramid_number), 128'(3));
    chk("single accum", 128'(out_accum), 128'(32'hFFFFFF80));
    chk("single count", 128'(count), 128'(1));
    idle(1'b1, 1'b0);
    chk("pop count", 128'(count), 128'(0));
    chk("pop valid", 128'(out_valid), 128'(0));

    // Masking
    idle(1'b0, 1'b1);
    repeat (10) cyc(1'b0, 1'b1, 32'd1, 32'd1, 4'd1, 32'd1, 1'b0, 1'b0);
    chk("mask count",  128'(count), 128'(0));
    chk("mask detect", 128'(detect_count), 128'(0));

    // Fill past full, then drain in order
    for (int i = 0; i < 20; i++) det_cyc(i, 1'b0);
    chk("fill count",    128'(count), 128'(16));
    chk("fill overflow", 128'(overflow), 128'(1));
    chk("fill drop",     128'(drop_count), 128'(4));
    chk("fill detect",   128'(detect_count), 128'(20));
    chk("fill detect4",  128'(detect_count4), 128'(15));
    for (int i = 0; i < 16; i++) begin
      chk("drain x", 128'(out_top_left[0]), 128'(i));
      idle(1'b1, 1'b0);
    end
    chk("drain empty", 128'(out_valid), 128'(0));

    // Full plus simultaneous push and pop
    idle(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) det_cyc(100 + i, 1'b0);
    det_cyc(99, 1'b1);
    chk("pp count", 128'(count), 128'(16));
    chk("pp drop",  128'(drop_count), 128'(0));
    for (int i = 0; i < 16; i++) begin
      chk("pp drain x", 128'(out_top_left[0]), 128'((i < 15) ? 101 + i : 99));
      idle(1'b1, 1'b0);
    end

    // frame_clear beats same-cycle det and pop
    for (int i = 0; i < 5; i++) det_cyc(200 + i, 1'b0);
    cyc(1'b1, 1'b1, 32'd77, 32'd77, 4'd7, 32'd77, 1'b1, 1'b1);
    chk("clr count",    128'(count), 128'(0));
    chk("clr detect",   128'(detect_count), 128'(0));
    chk("clr drop",     128'(drop_count), 128'(0));
    chk("clr overflow", 128'(overflow), 128'(0));
    idle(1'b0, 1'b0);
    chk("clr valid", 128'(out_valid), 128'(0));

    // Saturation: fill, then 20 more with the FIFO held full
    for (int i = 0; i < 16; i++) det_cyc(300 + i, 1'b0);
    for (int i = 0; i < 20; i++) det_cyc(400 + i, 1'b0);
    chk("sat drop4",   128'(drop_count4), 128'(15));
    chk("sat detect4", 128'(detect_count4), 128'(15));
    chk("sat drop",    128'(drop_count), 128'(20));
    chk("sat detect",  128'(detect_count), 128'(36));
    chk("sat count",   128'(count), 128'(16));

    // Async reset mid-burst, away from any clock edge
    idle(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) det_cyc(500 + i, 1'b0);
    in_window_valid = 1'b1;
    in_top_left_ready = 1'b1;
    #3;
    reset = 1'b1;
    model_clear();
    #1;
    chk_all_zero("async reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(1'b0, 1'b0);
    chk("post reset count", 128'(count), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end

endmodule
